// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared types and constants for the iterative divide sequencer.
package div_seq_pkg;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
   localparam int DEF_WIDTH = 32;
   localparam logic [63:0] DIV0_QUOT = '1;
endpackage

// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if: request handshake plus HiLo result bus of the divide sequencer.
interface div_seq_ctrl_if
   import div_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) ();
   logic               req_valid;
   logic               req_ready;
   logic [WIDTH-1:0]   dividend;
   logic [WIDTH-1:0]   divisor;
   logic               div_signed;
   logic               abort;
   logic               hilo_we;
   logic [2*WIDTH-1:0] hilo_data;
   logic               div_zero;
   logic               busy;
   modport master (
      output req_valid, dividend, divisor, div_signed, abort,
      input  req_ready, hilo_we, hilo_data, div_zero, busy
   );
   modport slave (
      input  req_valid, dividend, divisor, div_signed, abort,
      output req_ready, hilo_we, hilo_data, div_zero, busy
   );
endinterface

// File: rtl/div_seq_ctrl_step.sv
// div_step: one restoring shift-subtract iteration on magnitudes.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);
   logic [WIDTH:0] sh, diff;
   // Shifted remainder keeps its carry bit so divisors above 2^(W-1) still compare correctly.
   always_comb begin
      sh    = {rem_i, quo_i[WIDTH-1]};
      diff  = sh - {1'b0, dvs_i};
      rem_o = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};
   end
endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: iterative restoring divider sequencer loading {rem, quo} into HiLo.
// Signed operation is compiled in only when SIGNED_DIV_EN is defined.
module div_seq_ctrl
   import div_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input logic           clk,
   input logic           reset,
   div_seq_ctrl_if.slave div_if
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   state_e               state_q;
   logic [CW-1:0]        cnt_q;
   logic [WIDTH-1:0]     rem_q, quo_q, dvs_q;
   logic [WIDTH-1:0]     step_rem, step_quo, ld_dvd, ld_dvs, fix_rem, fix_quo;
   logic                 hilo_we_q, div_zero_q;
   logic [2*WIDTH-1:0]   hilo_q;
   logic                 fire;
   assign fire = div_if.req_valid && state_q == IDLE;
`ifdef SIGNED_DIV_EN
   logic dvd_neg, dvs_neg, qneg_q, rneg_q;
   assign dvd_neg = div_if.div_signed && div_if.dividend[WIDTH-1];
   assign dvs_neg = div_if.div_signed && div_if.divisor[WIDTH-1];
   assign ld_dvd  = dvd_neg ? -div_if.dividend : div_if.dividend;
   assign ld_dvs  = dvs_neg ? -div_if.divisor : div_if.divisor;
   assign fix_quo = qneg_q ? -quo_q : quo_q;
   assign fix_rem = rneg_q ? -rem_q : rem_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
      end else if (fire) begin
         qneg_q <= dvd_neg ^ dvs_neg;
         rneg_q <= dvd_neg;
      end
`else
   logic unused_sign;
   assign unused_sign = div_if.div_signed;
   assign ld_dvd  = div_if.dividend;
   assign ld_dvs  = div_if.divisor;
   assign fix_quo = quo_q;
   assign fix_rem = rem_q;
`endif
   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i(rem_q),
      .quo_i(quo_q),
      .dvs_i(dvs_q),
      .rem_o(step_rem),
      .quo_o(step_quo)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         hilo_we_q  <= 1'b0;
         hilo_q     <= '0;
         div_zero_q <= 1'b0;
      end else begin
         hilo_we_q <= 1'b0;
         case (state_q)
            IDLE: if (div_if.req_valid) begin
               rem_q <= '0;
               quo_q <= ld_dvd;
               dvs_q <= ld_dvs;
               cnt_q <= '0;
               if (div_if.divisor == '0) begin
                  state_q    <= DONE;
                  hilo_we_q  <= 1'b1;
                  hilo_q     <= {div_if.dividend, DIV0_QUOT[WIDTH-1:0]};
                  div_zero_q <= 1'b1;
               end else
                  state_q <= CALC;
            end
            CALC: if (div_if.abort)
               state_q <= IDLE;
            else begin
               rem_q   <= step_rem;
               quo_q   <= step_quo;
               cnt_q   <= (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
               state_q <= (cnt_q == LAST) ? FIX : CALC;
            end
            FIX: if (div_if.abort)
               state_q <= IDLE;
            else begin
               state_q    <= DONE;
               hilo_we_q  <= 1'b1;
               hilo_q     <= {fix_rem, fix_quo};
               div_zero_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   assign div_if.req_ready = state_q == IDLE;
   assign div_if.busy      = state_q != IDLE;
   assign div_if.hilo_we   = hilo_we_q;
   assign div_if.hilo_data = hilo_q;
   assign div_if.div_zero  = div_zero_q;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed self-checking bench for the divide sequencer (WIDTH=32).
module tb_div_seq_ctrl;
   import div_seq_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   errs = 0;
   int   checks = 0;
   int   cyc;
   logic saw;
   div_seq_ctrl_if #(.WIDTH(32)) bus ();
   div_seq_ctrl #(.WIDTH(32)) dut (
      .clk(clk),
      .reset(reset),
      .div_if(bus)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // Handshake from IDLE; returns in cycle 1 with req_valid dropped.
   task automatic go(input logic [31:0] a, input logic [31:0] b, input logic s);
      bus.dividend   = a;
      bus.divisor    = b;
      bus.div_signed = s;
      bus.req_valid  = 1'b1;
      tick();
      bus.req_valid  = 1'b0;
   endtask
   task automatic wait_we(inout int c);
      while (!bus.hilo_we && c < 200) begin
         tick();
         c++;
      end
   endtask
   task automatic watch_no_we(output logic s);
      s = 1'b0;
      repeat (40) begin
         if (bus.hilo_we) s = 1'b1;
         tick();
      end
   endtask
   initial begin
      bus.req_valid = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      bus.div_signed = 1'b0;
      bus.abort = 1'b0;
      repeat (2) tick();
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_we", 64'(bus.hilo_we), 64'd0);
      chk("rst_data", bus.hilo_data, 64'd0);
      chk("rst_dz", 64'(bus.div_zero), 64'd0);
      reset = 1'b1;
      tick();
      // 100/7 unsigned
      go(32'd100, 32'd7, 1'b0);
      cyc = 1;
      chk("u_busy_c1", 64'(bus.busy), 64'd1);
      chk("u_ready_c1", 64'(bus.req_ready), 64'd0);
      wait_we(cyc);
      chk("u_we_cycle", 64'(cyc), 64'd34);
      chk("u_data", bus.hilo_data, {32'd2, 32'd14});
      chk("u_dz", 64'(bus.div_zero), 64'd0);
      tick();
      chk("u_we_pulse", 64'(bus.hilo_we), 64'd0);
      chk("u_ready_c35", 64'(bus.req_ready), 64'd1);
      // -7/2 signed request
      go(32'hFFFF_FFF9, 32'd2, 1'b1);
      cyc = 1;
      wait_we(cyc);
      chk("s_we_cycle", 64'(cyc), 64'd34);
`ifdef SIGNED_DIV_EN
      chk("s_data", bus.hilo_data, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
`else
      chk("s_data", bus.hilo_data, {32'd1, 32'h7FFF_FFFC});
`endif
      tick();
      // 5/0
      go(32'd5, 32'd0, 1'b0);
      chk("z_we_c1", 64'(bus.hilo_we), 64'd1);
      chk("z_data", bus.hilo_data, {32'd5, 32'hFFFF_FFFF});
      chk("z_dz", 64'(bus.div_zero), 64'd1);
      tick();
      chk("z_ready_c2", 64'(bus.req_ready), 64'd1);
      chk("z_we_c2", 64'(bus.hilo_we), 64'd0);
      // abort in cycle 10
      go(32'd1000, 32'd3, 1'b0);
      cyc = 1;
      while (cyc < 10) begin
         tick();
         cyc++;
      end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("a_ready_c11", 64'(bus.req_ready), 64'd1);
      chk("a_data_hold", bus.hilo_data, {32'd5, 32'hFFFF_FFFF});
      watch_no_we(saw);
      chk("a_no_we", 64'(saw), 64'd0);
      go(32'd9, 32'd3, 1'b0);
      cyc = 1;
      wait_we(cyc);
      chk("a2_we_cycle", 64'(cyc), 64'd34);
      chk("a2_data", bus.hilo_data, {32'd0, 32'd3});
      chk("a2_dz", 64'(bus.div_zero), 64'd0);
      tick();
      // reset in cycle 5
      go(32'd1000, 32'd3, 1'b0);
      repeat (4) tick();
      reset = 1'b0;
      #1;
      chk("r_busy", 64'(bus.busy), 64'd0);
      chk("r_data", bus.hilo_data, 64'd0);
      chk("r_we", 64'(bus.hilo_we), 64'd0);
      tick();
      reset = 1'b1;
      watch_no_we(saw);
      chk("r_no_we", 64'(saw), 64'd0);
      // held req_valid, two back-to-back requests
      bus.dividend   = 32'h8000_0000;
      bus.divisor    = 32'hFFFF_FFFF;
      bus.div_signed = 1'b1;
      bus.req_valid  = 1'b1;
      tick();
      cyc = 1;
      wait_we(cyc);
      chk("h_we_cycle", 64'(cyc), 64'd34);
`ifdef SIGNED_DIV_EN
      chk("h_data", bus.hilo_data, {32'd0, 32'h8000_0000});
`else
      chk("h_data", bus.hilo_data, {32'h8000_0000, 32'd0});
`endif
      bus.dividend   = 32'd20;
      bus.divisor    = 32'd6;
      bus.div_signed = 1'b0;
      tick();
      cyc++;
      chk("h_ready_c35", 64'(bus.req_ready), 64'd1);
      tick();
      cyc++;
      bus.req_valid = 1'b0;
      chk("h_busy_c36", 64'(bus.busy), 64'd1);
      wait_we(cyc);
      chk("h2_we_cycle", 64'(cyc), 64'd69);
      chk("h2_data", bus.hilo_data, {32'd2, 32'd3});
      tick();
      chk("h2_idle", 64'(bus.req_ready), 64'd1);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
